// File: rtl/jt12_fir_sched_if.sv
// Source-sample and FIR-slot bus of the FM/PSG scheduler.
// The scheduler is the slave: it consumes strobes and fir_ready and drives the slot outputs.
interface jt12_fir_sched_if #(parameter int DW = 9);
  logic          en;
  logic          fm_sample;
  logic [DW-1:0] fm_left;
  logic [DW-1:0] fm_right;
  logic          psg_sample;
  logic [DW-1:0] psg_left;
  logic [DW-1:0] psg_right;
  logic          fir_ready;
  logic          clr_ovr;
  logic          fir_sample;
  logic [DW-1:0] fir_left;
  logic [DW-1:0] fir_right;
  logic [1:0]    fir_slot;
  logic          fm_ovr;
  logic          psg_ovr;

  modport master (
    output en, fm_sample, fm_left, fm_right, psg_sample, psg_left, psg_right,
           fir_ready, clr_ovr,
    input  fir_sample, fir_left, fir_right, fir_slot, fm_ovr, psg_ovr
  );

  modport slave (
    input  en, fm_sample, fm_left, fm_right, psg_sample, psg_left, psg_right,
           fir_ready, clr_ovr,
    output fir_sample, fir_left, fir_right, fir_slot, fm_ovr, psg_ovr
  );
endinterface

// File: rtl/jt12_fir_sched.sv
// Shares one stereo FIR interpolator between FM and PSG. Latest sample of each source is
// held and issued into fixed-cadence slots FM,Z,PSG,Z (or FM,PSG without zero stuffing).
module jt12_fir_sched #(
  parameter int DW       = 9,
  parameter int SLOT_CYC = 42,
  parameter bit ZSTUFF   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  jt12_fir_sched_if.slave  bus
);
  localparam int            CW      = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] CNT_END = CW'(SLOT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    ptr, ptr_nxt;
  logic          go;
  logic          fm_iss, psg_iss;
  logic [DW-1:0] hold_fm_l, hold_fm_r, hold_psg_l, hold_psg_r;
  logic          pend_fm, pend_psg;

  // Slot pointer sequence; without stuffing the zero slots are skipped.
  assign ptr_nxt = ZSTUFF ? ptr + 2'd1 : ((ptr == 2'd0) ? 2'd2 : 2'd0);
  assign fm_iss  = go && (ptr == 2'd0);
  assign psg_iss = go && (ptr == 2'd2);

  // Next state; go marks the edge that launches a slot (fir_sample visible in ISSUE).
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    case (state)
      IDLE: if (bus.en && bus.fir_ready) begin
        state_nxt = ISSUE;
        go        = 1'b1;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: if (cnt == CNT_END) begin
        if (!bus.en) state_nxt = IDLE;
        else if (bus.fir_ready) begin
          state_nxt = ISSUE;
          go        = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Slot timer (holds at its end value while the FIR stalls) and slot pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ptr <= 2'd0;
    end else begin
      if (state == ISSUE)                     cnt <= CW'(1);
      else if (state == WAIT && cnt != CNT_END) cnt <= cnt + CW'(1);
      if (go)                                 ptr <= ptr_nxt;
      else if (state == WAIT && cnt == CNT_END && !bus.en) ptr <= 2'd0;
    end
  end

  // Holding registers, pending flags and sticky overruns; a set beats clr_ovr.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_fm_l  <= '0;
      hold_fm_r  <= '0;
      hold_psg_l <= '0;
      hold_psg_r <= '0;
      pend_fm    <= 1'b0;
      pend_psg   <= 1'b0;
      bus.fm_ovr  <= 1'b0;
      bus.psg_ovr <= 1'b0;
    end else begin
      if (bus.fm_sample) begin
        hold_fm_l <= bus.fm_left;
        hold_fm_r <= bus.fm_right;
      end
      if (bus.psg_sample) begin
        hold_psg_l <= bus.psg_left;
        hold_psg_r <= bus.psg_right;
      end
      pend_fm  <= bus.fm_sample  | (pend_fm  & ~fm_iss);
      pend_psg <= bus.psg_sample | (pend_psg & ~psg_iss);
      if (bus.fm_sample && pend_fm && !fm_iss) bus.fm_ovr <= 1'b1;
      else if (bus.clr_ovr)                   bus.fm_ovr <= 1'b0;
      if (bus.psg_sample && pend_psg && !psg_iss) bus.psg_ovr <= 1'b1;
      else if (bus.clr_ovr)                      bus.psg_ovr <= 1'b0;
    end
  end

  // Registered slot outputs; data holds between pulses, zero slots drive exact 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fir_sample <= 1'b0;
      bus.fir_left   <= '0;
      bus.fir_right  <= '0;
      bus.fir_slot   <= 2'd0;
    end else begin
      bus.fir_sample <= go;
      if (go) begin
        bus.fir_slot <= ptr;
        case (ptr)
          2'd0:    begin bus.fir_left <= hold_fm_l;  bus.fir_right <= hold_fm_r;  end
          2'd2:    begin bus.fir_left <= hold_psg_l; bus.fir_right <= hold_psg_r; end
          default: begin bus.fir_left <= '0;         bus.fir_right <= '0;         end
        endcase
      end
    end
  end
endmodule
